// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding muxes, ALU, branch/jump resolution and the EX/MEM register.
// The alu module below is the shared datapath ALU that decode targets with ALUControlE.

module alu #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      alu_control,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            negative,
   output logic            overflow,
   output logic            carry
);

   // Opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 sll.
   logic            sub;
   logic            arith;
   logic [XLEN-1:0] b_eff;
   logic [XLEN:0]   sum;

   assign sub   = (alu_control == 3'b001);
   assign arith = (alu_control[2:1] == 2'b00);
   assign b_eff = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};

   // NOTE: every output of a combinational block gets a default first, otherwise
   // an uncovered path holds its old value and synthesis infers a latch.
   always_comb begin
      result = '0;
      case (alu_control)
         3'b000,
         3'b001:  result = sum[XLEN-1:0];
         3'b010:  result = a & b;
         3'b011:  result = a | b;
         3'b100:  result = a ^ b;
         3'b101:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         3'b110:  result = {{(XLEN-1){1'b0}}, a < b};
         default: result = a << b[4:0];
      endcase
   end

   assign zero     = (result == '0);
   assign negative = result[XLEN-1];
   assign overflow = arith & (a[XLEN-1] == b_eff[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
   assign carry    = arith & sum[XLEN];

endmodule

module execute_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ValidE,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            ResultSrcE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            JalrE,
   input  logic            ALUSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [2:0]      Funct3E,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [RA_W-1:0] RD_E,
   input  logic [1:0]      ForwardA_E,
   input  logic [1:0]      ForwardB_E,
   input  logic [XLEN-1:0] ResultW,
   input  logic            StallM,
   input  logic            FlushM,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic            ResultSrcM,
   output logic            ValidM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [RA_W-1:0] RD_M
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_write;
      logic            result_src;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] write_data;
      logic [XLEN-1:0] pc_plus4;
      logic [RA_W-1:0] rd;
   } ex_mem_t;

   ex_mem_t         ex_mem;
   ex_mem_t         ex_mem_next;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] write_data;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            zero;
   logic            negative;
   logic            overflow;
   logic            carry_unused;
   logic            borrow;
   logic [XLEN-1:0] diff_unused;
   logic            taken;
   logic [XLEN-1:0] jalr_sum;

   // Forward select 11 is not produced by the hazard unit and falls back to the register file.
   always_comb begin
      src_a = RD1_E;
      case (ForwardA_E)
         2'b01:   src_a = ResultW;
         2'b10:   src_a = ex_mem.alu_result;
         default: src_a = RD1_E;
      endcase
   end

   always_comb begin
      write_data = RD2_E;
      case (ForwardB_E)
         2'b01:   write_data = ResultW;
         2'b10:   write_data = ex_mem.alu_result;
         default: write_data = RD2_E;
      endcase
   end

   assign src_b = ALUSrcE ? Imm_Ext_E : write_data;

   alu #(.XLEN(XLEN)) u_alu (
      .a           (src_a),
      .b           (src_b),
      .alu_control (ALUControlE),
      .result      (alu_result),
      .zero        (zero),
      .negative    (negative),
      .overflow    (overflow),
      .carry       (carry_unused)
   );

   // Unsigned compare is done locally so BLTU/BGEU do not depend on the ALU carry convention.
   assign {borrow, diff_unused} = {1'b0, src_a} - {1'b0, src_b};

   always_comb begin
      taken = 1'b0;
      case (Funct3E)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = negative ^ overflow;
         3'b101:  taken = ~(negative ^ overflow);
         3'b110:  taken = borrow;
         3'b111:  taken = ~borrow;
         default: taken = 1'b0;
      endcase
   end

   assign PCSrcE    = ValidE & (JumpE | (BranchE & taken));
   assign jalr_sum  = src_a + Imm_Ext_E;
   assign PCTargetE = JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (PCE + Imm_Ext_E);

   always_comb begin
      ex_mem_next            = '0;
      ex_mem_next.valid      = ValidE;
      ex_mem_next.reg_write  = RegWriteE & ValidE;
      ex_mem_next.mem_write  = MemWriteE & ValidE;
      ex_mem_next.result_src = ResultSrcE;
      ex_mem_next.alu_result = alu_result;
      ex_mem_next.write_data = write_data;
      ex_mem_next.pc_plus4   = PCPlus4E;
      ex_mem_next.rd         = RD_E;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   // Flush takes priority over stall so a squashed instruction never lingers in M.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_mem <= '0;
      end else if (FlushM) begin
         ex_mem <= '0;
      end else if (!StallM) begin
         ex_mem <= ex_mem_next;
      end
   end

   assign ValidM     = ex_mem.valid;
   assign RegWriteM  = ex_mem.reg_write;
   assign MemWriteM  = ex_mem.mem_write;
   assign ResultSrcM = ex_mem.result_src;
   assign ALUResultM = ex_mem.alu_result;
   assign WriteDataM = ex_mem.write_data;
   assign PCPlus4M   = ex_mem.pc_plus4;
   assign RD_M       = ex_mem.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the execute stage and EX/MEM register.

module tb_execute_stage;

   logic        clk;
   logic        rst;
   logic        ValidE, RegWriteE, MemWriteE, ResultSrcE;
   logic        BranchE, JumpE, JalrE, ALUSrcE;
   logic [2:0]  ALUControlE, Funct3E;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RD_E;
   logic [1:0]  ForwardA_E, ForwardB_E;
   logic [31:0] ResultW;
   logic        StallM, FlushM;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM, ValidM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RD_M;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of the M-stage contents.
   logic        m_valid, m_rw, m_mw, m_rs;
   logic [31:0] m_alu, m_wd, m_pc4;
   logic [4:0]  m_rd;

   execute_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk(clk), .rst(rst),
      .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .Funct3E(Funct3E),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
      .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
      .StallM(StallM), .FlushM(FlushM),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RD_M(RD_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd6:    return (a < b) ? 32'd1 : 32'd0;
         default: return a << b[4:0];
      endcase
   endfunction

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'b01) return ResultW;
      if (sel == 2'b10) return m_alu;
      return rf;
   endfunction

   // Branch outcome from the architectural meaning of each branch.
   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0;
      m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
   endtask

   task automatic check_m(input string where);
      check({where, ".ValidM"},     ValidM,     m_valid);
      check({where, ".RegWriteM"},  RegWriteM,  m_rw);
      check({where, ".MemWriteM"},  MemWriteM,  m_mw);
      check({where, ".ResultSrcM"}, ResultSrcM, m_rs);
      check({where, ".ALUResultM"}, ALUResultM, m_alu);
      check({where, ".WriteDataM"}, WriteDataM, m_wd);
      check({where, ".PCPlus4M"},   PCPlus4M,   m_pc4);
      check({where, ".RD_M"},       RD_M,       m_rd);
   endtask

   // Called with inputs settled, well before the rising edge; returns at edge + 1.
   task automatic cycle(input string where);
      logic [31:0] a, wd, b, res, tgt;
      logic        pcsrc;
      a     = fwd(ForwardA_E, RD1_E);
      wd    = fwd(ForwardB_E, RD2_E);
      b     = ALUSrcE ? Imm_Ext_E : wd;
      res   = ref_alu(ALUControlE, a, b);
      pcsrc = ValidE && (JumpE || (BranchE && ref_taken(Funct3E, a, b)));
      tgt   = JalrE ? ((a + Imm_Ext_E) & 32'hFFFF_FFFE) : (PCE + Imm_Ext_E);
      #1;
      check({where, ".PCSrcE"},    PCSrcE,    pcsrc);
      check({where, ".PCTargetE"}, PCTargetE, tgt);
      @(posedge clk);
      if (FlushM) begin
         model_reset();
      end else if (!StallM) begin
         m_valid = ValidE;
         m_rw    = RegWriteE && ValidE;
         m_mw    = MemWriteE && ValidE;
         m_rs    = ResultSrcE;
         m_alu   = res;
         m_wd    = wd;
         m_pc4   = PCPlus4E;
         m_rd    = RD_E;
      end
      #1;
      check_m(where);
   endtask

   task automatic drive_idle();
      ValidE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
      BranchE = 0; JumpE = 0; JalrE = 0; ALUSrcE = 0;
      ALUControlE = 0; Funct3E = 0;
      RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
      ForwardA_E = 0; ForwardB_E = 0; ResultW = 0; StallM = 0; FlushM = 0;
   endtask

   task automatic drive_random();
      ValidE      = ($urandom_range(0, 3) != 0);
      RegWriteE   = $urandom_range(0, 1);
      MemWriteE   = $urandom_range(0, 1);
      ResultSrcE  = $urandom_range(0, 1);
      ALUSrcE     = $urandom_range(0, 1);
      ALUControlE = 3'($urandom_range(0, 7));
      Funct3E     = 3'($urandom_range(0, 7));
      BranchE     = ($urandom_range(0, 2) == 0);
      JumpE       = ($urandom_range(0, 5) == 0);
      JalrE       = JumpE && $urandom_range(0, 1);
      if (BranchE) ALUControlE = 3'b001;
      // Small operands half the time so equal/near-equal compares actually occur.
      RD1_E       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4)) : $urandom;
      RD2_E       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 4)) : $urandom;
      Imm_Ext_E   = $urandom;
      PCE         = $urandom;
      PCPlus4E    = PCE + 32'd4;
      RD_E        = 5'($urandom_range(0, 31));
      ForwardA_E  = 2'($urandom_range(0, 3));
      ForwardB_E  = 2'($urandom_range(0, 3));
      ResultW     = $urandom;
      StallM      = ($urandom_range(0, 5) == 0);
      FlushM      = ($urandom_range(0, 9) == 0);
   endtask

   initial begin
      rst = 0;
      drive_idle();
      model_reset();

      // Reset held with random inputs: nothing may load.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_random();
         @(posedge clk);
         #1;
         check_m("reset_hold");
      end
      @(negedge clk);
      rst = 1;
      drive_idle();
      #1;
      check_m("reset_release");
      @(posedge clk);
      #1;
      check_m("bubble_after_reset");

      // ADD with ResultW forwarded into A: 7 + 3.
      ValidE = 1; RegWriteE = 1; RD_E = 5'd9; PCPlus4E = 32'h44;
      RD1_E = 32'd5; ResultW = 32'd7; ForwardA_E = 2'b01; RD2_E = 32'd3;
      cycle("add_fwd_w");
      check("add_fwd_w.value", ALUResultM, 32'd10);
      // ALUResultM forwarded into B: 1 + 10.
      RD1_E = 32'd1; ForwardA_E = 2'b00; ForwardB_E = 2'b10;
      cycle("add_fwd_m");
      check("add_fwd_m.value", ALUResultM, 32'd11);

      // Branches via subtract.
      drive_idle();
      ValidE = 1; BranchE = 1; ALUControlE = 3'b001; PCE = 32'h100; Imm_Ext_E = 32'h20;
      Funct3E = 3'b000; RD1_E = 32'd4; RD2_E = 32'd4;
      #1;
      check("beq.taken", PCSrcE, 1'b1);
      check("beq.target", PCTargetE, 32'h120);
      cycle("beq");
      Funct3E = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
      #1;
      check("blt.taken", PCSrcE, 1'b1);
      cycle("blt");
      Funct3E = 3'b110;
      #1;
      check("bltu.not_taken", PCSrcE, 1'b0);
      cycle("bltu");
      Funct3E = 3'b111;
      #1;
      check("bgeu.taken", PCSrcE, 1'b1);
      cycle("bgeu");
      ValidE = 0;
      #1;
      check("bgeu_bubble.pcsrc", PCSrcE, 1'b0);
      cycle("bgeu_bubble");

      // JALR clears bit 0 of the target.
      drive_idle();
      ValidE = 1; RegWriteE = 1; JumpE = 1; JalrE = 1; RD_E = 5'd1;
      RD1_E = 32'h1001; Imm_Ext_E = 32'h4; PCE = 32'h2000; PCPlus4E = 32'h2004;
      #1;
      check("jalr.pcsrc", PCSrcE, 1'b1);
      check("jalr.target", PCTargetE, 32'h1004);
      cycle("jalr");
      check("jalr.link", PCPlus4M, 32'h2004);

      // Stall holds M for two cycles while E changes; flush wins over stall.
      drive_idle();
      ValidE = 1; RegWriteE = 1; MemWriteE = 1; RD1_E = 32'd10; RD2_E = 32'd20; RD_E = 5'd3;
      cycle("stall_load");
      check("stall_load.value", ALUResultM, 32'd30);
      StallM = 1;
      for (int i = 0; i < 2; i++) begin
         RD1_E = $urandom; RD2_E = $urandom; RD_E = 5'($urandom_range(0, 31));
         ForwardA_E = 2'b10;
         cycle("stall_hold");
         check("stall_hold.value", ALUResultM, 32'd30);
         check("stall_hold.valid", ValidM, 1'b1);
      end
      FlushM = 1;
      cycle("stall_flush");
      check("flush.valid", ValidM, 1'b0);
      check("flush.regwrite", RegWriteM, 1'b0);
      check("flush.memwrite", MemWriteM, 1'b0);

      // Async reset between edges, then the first edge after release loads normally.
      drive_idle();
      ValidE = 1; RegWriteE = 1; RD1_E = 32'h55; RD_E = 5'd7; PCPlus4E = 32'h88;
      cycle("pre_async");
      #1;
      rst = 0;
      #1;
      model_reset();
      check_m("async_reset");
      #1;
      rst = 1;
      cycle("post_async");
      check("post_async.valid", ValidM, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive_random();
         cycle("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32I pipeline execute stage plus EX/MEM pipeline register.
- Takes ID/EX register contents and applies forwarding muxes. Selects ALU operands and instantiates the existing alu module.
- Resolves branches and jumps in the E cycle, then registers results into the M stage.
- Drives PCSrcE and PCTargetE back to the fetch stage.

Parameters:
- XLEN, 32, datapath width; must be 32 to match alu.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ValidE  in  1  E-stage instruction valid (0 = bubble).
- RegWriteE, MemWriteE, ResultSrcE  in  1 each  control from ID/EX.
- BranchE, JumpE, JalrE, ALUSrcE  in  1 each  control from ID/EX.
- ALUControlE  in  3  alu opcode.
- Funct3E  in  3  branch type.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands.
- RD_E  in  5  destination register.
- ForwardA_E, ForwardB_E  in  2 each  hazard-unit select; 00 RD1/RD2, 01 ResultW, 10 ALUResultM, 11 treated as 00.
- ResultW  in  32  writeback value.
- StallM  in  1  hold EX/MEM register.
- FlushM  in  1  load bubble into EX/MEM.
- PCSrcE  out  1  redirect fetch (combinational).
- PCTargetE  out  32  redirect address (combinational).
- RegWriteM, MemWriteM, ResultSrcM, ValidM  out  1 each  registered.
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered.
- RD_M  out  5  registered.

Behaviour:
- Operand selection:
  - SrcAE = forward mux A.
  - WriteDataE = forward mux B.
  - SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
  - The ALUResultM forward path uses the registered output of this block.
- ALU: alu instance gets A=SrcAE, B=SrcBE, ALUControl=ALUControlE. Result, Zero, Negative and OverFlow are used; Carry is ignored.
- Branch compare: flags come from the alu, which decode must drive with ALUControlE=001 (subtract) for branches.
  - Funct3 000 BEQ: Zero. 001 BNE: ~Zero.
  - 100 BLT: Negative^OverFlow. 101 BGE: ~(Negative^OverFlow).
  - 110 BLTU: borrow of a local 33-bit {0,SrcAE}-{0,SrcBE}. 111 BGEU: ~borrow.
  - 010/011: not taken.
- PCSrcE = ValidE & (JumpE | (BranchE & taken)).
- PCTargetE = JalrE ? ((SrcAE + Imm_Ext_E) & ~1) : (PCE + Imm_Ext_E). All sums are 32-bit and wrap modulo 2^32.
- EX/MEM register update priority on each rising edge:
  1. rst low (async, immediate): all registered outputs = 0.
  2. FlushM: ValidM, RegWriteM, MemWriteM = 0; other fields don't-care but are driven to 0.
  3. StallM: every registered output holds its value.
  4. Otherwise load: ValidM <- ValidE, RegWriteM <- RegWriteE&ValidE, MemWriteM <- MemWriteE&ValidE, ALUResultM <- alu Result, WriteDataM <- WriteDataE, RD_M <- RD_E, PCPlus4M <- PCPlus4E, ResultSrcM <- ResultSrcE.
- FlushM and StallM together: flush wins.
- Latency: E-cycle values appear on M outputs one cycle later. PCSrcE/PCTargetE have zero latency.
- Reset deasserted mid-stream: the first edge after release loads normally, with no extra bubble.
- While StallM is high, the forward value ALUResultM stays stable.

Test Plan:
- Reset: hold rst=0 with random inputs, then release. All M outputs 0 before the first edge; ValidM=0 until a valid E instruction is loaded.
- ADD with forwarding: RD1_E=5, ResultW=7, ForwardA=01, RD2_E=3, ALUSrc=0, ALUControl=000. Next cycle ALUResultM=10. Then ForwardB=10 with RD1_E=1 gives ALUResultM=11.
- Branches, ALUControl=001:
  - BEQ with 4,4: PCSrcE=1, PCTargetE=PCE+Imm.
  - BLT with -1 vs 1: taken.
  - BLTU with 0xFFFFFFFF vs 1: not taken.
  - BGEU with same operands: taken.
  - Any taken case with ValidE=0: PCSrcE=0.
- JALR: SrcAE=0x1001, Imm=0x4. PCTargetE=0x1004 (bit0 cleared), PCSrcE=1; next cycle PCPlus4M = the PCPlus4E presented with the JALR.
- Stall/flush: StallM for 2 cycles while inputs change, so outputs hold. Then StallM=FlushM=1: ValidM=RegWriteM=MemWriteM=0.
- Async reset mid-operation: pulse rst low between edges. Outputs go to 0 immediately, without waiting for clk.
